// File: rtl/armleocpu_simple_bus_arbiter_if.sv
// Requester-side and downstream register-bus signals of the simple bus arbiter.
// Handshake: a requester holds req_valid until it sees its one-cycle req_ready pulse; it must drop or re-present req_valid the cycle after.
interface armleocpu_simple_bus_arbiter_if #(
  parameter int REQ_COUNT = 2
);
  logic [REQ_COUNT-1:0]    req_valid;
  logic [REQ_COUNT-1:0]    req_write;
  logic [REQ_COUNT*32-1:0] req_address;
  logic [REQ_COUNT*32-1:0] req_wdata;
  logic [REQ_COUNT*4-1:0]  req_wstrb;
  logic [REQ_COUNT-1:0]    req_ready;
  logic [31:0]             req_rdata;
  logic [1:0]              req_resp;
  logic                    busy;

  logic [31:0]             address;
  logic                    write;
  logic                    read;
  logic [31:0]             write_data;
  logic [3:0]              write_byteenable;
  logic [31:0]             read_data;
  logic                    address_error;
  logic                    write_error;

  modport slave (
    input  req_valid, req_write, req_address, req_wdata, req_wstrb,
    output req_ready, req_rdata, req_resp, busy,
    output address, write, read, write_data, write_byteenable,
    input  read_data, address_error, write_error
  );

  modport master (
    output req_valid, req_write, req_address, req_wdata, req_wstrb,
    input  req_ready, req_rdata, req_resp, busy,
    input  address, write, read, write_data, write_byteenable,
    output read_data, address_error, write_error
  );
endinterface

// File: rtl/armleocpu_simple_bus_arbiter.sv
// Round-robin arbiter that serialises several requesters onto one register-bus slave,
// one downstream access per grant, with registered response returned to the winner only.
module armleocpu_simple_bus_arbiter #(
  parameter int REQ_COUNT = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  armleocpu_simple_bus_arbiter_if.slave        bus,
  output logic [1:0]                           state_o
);
  localparam int REQ_COUNT_WIDTH = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_ACCESS = 2'd1,
    STATE_RESP   = 2'd2
  } state_t;

  state_t                     state_q;
  logic [REQ_COUNT_WIDTH-1:0] winner_q;
  logic [REQ_COUNT_WIDTH-1:0] last_grant_q;
  logic [31:0]                address_q;
  logic [31:0]                wdata_q;
  logic [3:0]                 wstrb_q;
  logic                       write_q;
  logic [31:0]                rdata_q;
  logic [1:0]                 resp_q;
  logic [REQ_COUNT-1:0]       req_ready_q;

  logic                       grant_found;
  logic [REQ_COUNT_WIDTH-1:0] grant_idx;
  logic                       write_s;
  logic                       read_s;

  // Scan starts one past the last grant; one wrap subtraction suffices since last+1+k < 2*REQ_COUNT.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      cand = int'(last_grant_q) + 1 + k;
      if (cand >= REQ_COUNT) cand = cand - REQ_COUNT;
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = REQ_COUNT_WIDTH'(cand);
      end
    end
  end

  // Strobes follow the slave's combinational error flags so a rejected access never fires.
  assign write_s = (state_q == STATE_ACCESS) && write_q && !bus.address_error && !bus.write_error;
  assign read_s  = (state_q == STATE_ACCESS) && !write_q && !bus.address_error;

  assign bus.write            = write_s;
  assign bus.read             = read_s;
  assign bus.busy             = (state_q != STATE_IDLE);
  assign bus.address          = address_q;
  assign bus.write_data       = wdata_q;
  assign bus.write_byteenable = wstrb_q;
  assign bus.req_ready        = req_ready_q;
  assign bus.req_rdata        = rdata_q;
  assign bus.req_resp         = resp_q;
  assign state_o              = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STATE_IDLE;
      winner_q     <= '0;
      last_grant_q <= REQ_COUNT_WIDTH'(REQ_COUNT - 1);
      address_q    <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= 2'b00;
      req_ready_q  <= '0;
    end else begin
      case (state_q)
        STATE_IDLE: begin
          if (grant_found) begin
            winner_q  <= grant_idx;
            address_q <= bus.req_address[32*int'(grant_idx) +: 32];
            wdata_q   <= bus.req_wdata[32*int'(grant_idx) +: 32];
            wstrb_q   <= bus.req_wstrb[4*int'(grant_idx) +: 4];
            write_q   <= bus.req_valid[grant_idx] & bus.req_write[grant_idx];
            state_q   <= STATE_ACCESS;
          end
        end
        STATE_ACCESS: begin
          rdata_q     <= read_s ? bus.read_data : 32'h0;
          resp_q      <= bus.address_error ? 2'b11 :
                         (write_q && bus.write_error) ? 2'b10 : 2'b00;
          req_ready_q <= REQ_COUNT'(1) << winner_q;
          state_q     <= STATE_RESP;
        end
        STATE_RESP: begin
          last_grant_q <= winner_q;
          req_ready_q  <= '0;
          rdata_q      <= '0;
          resp_q       <= 2'b00;
          state_q      <= STATE_IDLE;
        end
        default: begin
          state_q <= STATE_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_armleocpu_simple_bus_arbiter.sv
// Directed bench for the round-robin simple bus arbiter with three requesters.
module tb_armleocpu_simple_bus_arbiter;
  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks;
  int         failures;

  armleocpu_simple_bus_arbiter_if #(.REQ_COUNT(3)) bus ();

  armleocpu_simple_bus_arbiter #(.REQ_COUNT(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    bus.req_write[i]             = wr;
    bus.req_address[32*i +: 32]  = addr;
    bus.req_wdata[32*i +: 32]    = wdata;
    bus.req_wstrb[4*i +: 4]      = wstrb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", bus.req_ready); end
    checks++; if ({bus.write, bus.read} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {bus.write, bus.read}); end
    checks++; if ({bus.address, bus.write_data, bus.write_byteenable} !== 68'h0) begin
      failures++; $display("FAIL reset_regs got=%h/%h/%h exp=0", bus.address, bus.write_data, bus.write_byteenable);
    end
    checks++; if ({bus.req_rdata, bus.req_resp} !== 34'h0) begin failures++; $display("FAIL reset_resp got=%h/%b exp=0", bus.req_rdata, bus.req_resp); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
    bus.read_data = 32'h1234_5678;
    bus.req_valid = 3'b001;
    step();
    checks++; if (bus.read !== 1'b1 || bus.write !== 1'b0) begin failures++; $display("FAIL read_strobe got=w%0b r%0b exp=w0 r1", bus.write, bus.read); end
    checks++; if (bus.address !== 32'h0000_4000) begin failures++; $display("FAIL read_address got=%h exp=00004000", bus.address); end
    checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 3'b000) begin failures++; $display("FAIL read_access_busy got=%0b/%b exp=1/000", bus.busy, bus.req_ready); end
    step();
    checks++; if (bus.read !== 1'b0) begin failures++; $display("FAIL read_strobe_len got=%0b exp=0", bus.read); end
    checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL read_ready got=%b exp=001", bus.req_ready); end
    checks++; if (bus.req_rdata !== 32'h1234_5678 || bus.req_resp !== 2'b00) begin
      failures++; $display("FAIL read_data got=%h/%b exp=12345678/00", bus.req_rdata, bus.req_resp);
    end
    bus.req_valid = 3'b000;
    step();
    checks++; if (bus.req_ready !== 3'b000 || bus.busy !== 1'b0 || bus.req_rdata !== 32'h0) begin
      failures++; $display("FAIL read_idle got=%b/%0b/%h exp=000/0/0", bus.req_ready, bus.busy, bus.req_rdata);
    end
  endtask

  task automatic test_write_strobes();
    set_req(1, 1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'b0011);
    bus.read_data = 32'hFFFF_FFFF;
    bus.req_valid = 3'b010;
    step();
    checks++; if (bus.write !== 1'b1 || bus.read !== 1'b0) begin failures++; $display("FAIL write_strobe got=w%0b r%0b exp=w1 r0", bus.write, bus.read); end
    checks++; if (bus.address !== 32'h4 || bus.write_data !== 32'hAABB_CCDD || bus.write_byteenable !== 4'b0011) begin
      failures++; $display("FAIL write_bus got=%h/%h/%b exp=00000004/aabbccdd/0011", bus.address, bus.write_data, bus.write_byteenable);
    end
    step();
    checks++; if (bus.write !== 1'b0 || bus.req_ready !== 3'b010 || bus.req_resp !== 2'b00) begin
      failures++; $display("FAIL write_resp got=%0b/%b/%b exp=0/010/00", bus.write, bus.req_ready, bus.req_resp);
    end
    checks++; if (bus.req_rdata !== 32'h0) begin failures++; $display("FAIL write_rdata got=%h exp=0", bus.req_rdata); end
    bus.req_valid = 3'b000;
    step();
  endtask

  task automatic test_errors();
    set_req(2, 1'b0, 32'h0000_9000, 32'h0, 4'hF);
    bus.read_data     = 32'hDEAD_BEEF;
    bus.address_error = 1'b1;
    bus.req_valid     = 3'b100;
    step();
    checks++; if (bus.read !== 1'b0 || bus.write !== 1'b0) begin failures++; $display("FAIL decerr_strobe got=w%0b r%0b exp=w0 r0", bus.write, bus.read); end
    step();
    checks++; if (bus.req_ready !== 3'b100 || bus.req_rdata !== 32'h0 || bus.req_resp !== 2'b11) begin
      failures++; $display("FAIL decerr_resp got=%b/%h/%b exp=100/0/11", bus.req_ready, bus.req_rdata, bus.req_resp);
    end
    bus.req_valid     = 3'b000;
    bus.address_error = 1'b0;
    step();
    set_req(0, 1'b1, 32'h0000_BFF8, 32'h1111_2222, 4'hF);
    bus.write_error = 1'b1;
    bus.req_valid   = 3'b001;
    step();
    checks++; if (bus.write !== 1'b0 || bus.read !== 1'b0) begin failures++; $display("FAIL slverr_strobe got=w%0b r%0b exp=w0 r0", bus.write, bus.read); end
    step();
    checks++; if (bus.req_ready !== 3'b001 || bus.req_resp !== 2'b10) begin
      failures++; $display("FAIL slverr_resp got=%b/%b exp=001/10", bus.req_ready, bus.req_resp);
    end
    bus.req_valid   = 3'b000;
    bus.write_error = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int         exp_order[8];
    logic [2:0] exp_ready;
    exp_order = '{0, 1, 2, 0, 1, 2, 0, 2};
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 32'h100 * i, 32'h0, 4'hF);
    bus.read_data = 32'h0000_00A5;
    bus.req_valid = 3'b111;
    for (int g = 0; g < 8; g++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        if (bus.req_ready !== 3'b000) break;
      end
      exp_ready = 3'b001 << exp_order[g];
      checks++; if (bus.req_ready !== exp_ready) begin
        failures++; $display("FAIL rr_grant%0d got=%b exp=%b", g, bus.req_ready, exp_ready);
      end
      if (g == 5) bus.req_valid = 3'b101;
    end
    bus.req_valid = 3'b000;
    step();
  endtask

  task automatic test_async_reset();
    bus.req_valid = 3'b001;
    step();
    step();
    bus.req_valid = 3'b000;
    step();
    set_req(1, 1'b1, 32'h0000_0040, 32'h5555_AAAA, 4'hF);
    bus.req_valid = 3'b010;
    step();
    checks++; if (bus.write !== 1'b1) begin failures++; $display("FAIL arst_pre_write got=%0b exp=1", bus.write); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.write !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 3'b000) begin
      failures++; $display("FAIL arst_drop got=w%0b b%0b r%b exp=w0 b0 r000", bus.write, bus.busy, bus.req_ready);
    end
    checks++; if (bus.address !== 32'h0 || bus.write_data !== 32'h0) begin
      failures++; $display("FAIL arst_regs got=%h/%h exp=0/0", bus.address, bus.write_data);
    end
    set_req(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h0000_000C, 32'h0, 4'hF);
    bus.read_data = 32'h1111_2222;
    bus.req_valid = 3'b011;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.req_ready !== 3'b000) break;
    end
    checks++; if (bus.req_ready !== 3'b001 || bus.req_rdata !== 32'h1111_2222) begin
      failures++; $display("FAIL arst_first_grant got=%b/%h exp=001/11112222", bus.req_ready, bus.req_rdata);
    end
    bus.req_valid = 3'b000;
    step();
  endtask

  task automatic test_dropped_valid();
    set_req(1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
    bus.read_data = 32'h0BAD_F00D;
    bus.req_valid = 3'b010;
    step();
    bus.req_valid = 3'b000;
    checks++; if (bus.read !== 1'b1) begin failures++; $display("FAIL drop_read got=%0b exp=1", bus.read); end
    step();
    checks++; if (bus.req_ready !== 3'b010 || bus.req_rdata !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL drop_ready got=%b/%h exp=010/0badf00d", bus.req_ready, bus.req_rdata);
    end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.req_ready !== 3'b000) begin
      failures++; $display("FAIL drop_idle got=%0b/%b exp=0/000", bus.busy, bus.req_ready);
    end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    rst_n             = 1'b0;
    bus.req_valid     = '0;
    bus.req_write     = '0;
    bus.req_address   = '0;
    bus.req_wdata     = '0;
    bus.req_wstrb     = '0;
    bus.read_data     = '0;
    bus.address_error = 1'b0;
    bus.write_error   = 1'b0;
    test_reset();
    test_single_read();
    test_write_strobes();
    test_errors();
    test_round_robin();
    test_async_reset();
    test_dropped_valid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/armleocpu_simple_bus_arbiter.md
# armleocpu_simple_bus_arbiter

Round-robin arbiter and sequencer that shares one simple register-bus slave (the CLINT register core, or any peripheral with the same address/write/read/read_data/address_error/write_error interface) between several requesters. It latches a winner's request, performs exactly one downstream access, and returns registered read data and an AXI-coded response to that requester only. It sits between the per-hart or per-master front-ends and the peripheral register file.

## Interface
- REQ_COUNT, 2, number of requesters; valid range 1..8
- REQ_COUNT_WIDTH, localparam, max(1, $clog2(REQ_COUNT))

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- req_valid  input  REQ_COUNT  per-requester access request; held until that requester's req_ready
- req_write  input  REQ_COUNT  1 = write, 0 = read
- req_address  input  REQ_COUNT*32  requester i occupies bits [32*i+31:32*i]
- req_wdata  input  REQ_COUNT*32  write data, same packing
- req_wstrb  input  REQ_COUNT*4  byte enables, requester i at [4*i+3:4*i]
- req_ready  output  REQ_COUNT  one-cycle completion pulse, at most one bit set
- req_rdata  output  32  read data, valid only with a req_ready bit
- req_resp  output  2  00 OKAY, 10 SLVERR, 11 DECERR; valid only with req_ready
- busy  output  1  high whenever state is not IDLE
- address  output  32  downstream address (registered)
- write  output  1  downstream write strobe
- read  output  1  downstream read strobe
- write_data  output  32  downstream write data (registered)
- write_byteenable  output  4  downstream byte enables (registered)
- read_data  input  32  downstream combinational read data
- address_error  input  1  downstream combinational decode error
- write_error  input  1  downstream combinational write-not-allowed (e.g. read-only mtime)

## Operation
- State machine: IDLE -> ACCESS -> RESP -> IDLE. Encoding free.
- IDLE: if any req_valid, select winner: first set bit scanning from (last_grant+1) mod REQ_COUNT upward with wrap. Latch winner index, its address, wdata, wstrb, write flag into registers driving address/write_data/write_byteenable. Go ACCESS. No request: stay IDLE, no register change.
- ACCESS (exactly one cycle): write = latched_write & !address_error & !write_error; read = !latched_write & !address_error. Capture: rdata = (read ? read_data : 0); resp = address_error ? 11 : (latched_write & write_error) ? 10 : 00. Go RESP.
- RESP: req_ready[winner] = 1, req_rdata/req_resp drive captured values; last_grant <= winner. Go IDLE.
- Once latched, the access completes even if req_valid drops (protocol violation; no abort).
- A requester must deassert or change req_valid the cycle after its req_ready; a held req_valid is treated as a new request.
- req_ready/req_rdata/req_resp are zero outside RESP. write/read are zero outside ACCESS.
- REQ_COUNT = 1: winner always 0; round-robin logic degenerates.

## Timing
- Reset (async assert, any state): state IDLE, last_grant = REQ_COUNT-1 (requester 0 wins first), req_ready 0, req_rdata 0, req_resp 00, busy 0, address 0, write 0, read 0, write_data 0, write_byteenable 0. In-flight access dropped, no req_ready issued; downstream strobe deasserts immediately.
- Latency: req_valid sampled in IDLE at edge N; ACCESS in cycle N+1 (strobe visible); req_ready in cycle N+2; next grant sampled at edge closing cycle N+3's IDLE. Throughput one access per 3 cycles.
- Downstream strobe is high exactly one cycle per access; never both write and read.
- Simultaneous requests: fairness guaranteed; with all requesters continuously valid, grants cycle 0,1,...,REQ_COUNT-1,0.
- New request arriving during ACCESS/RESP waits; sampled at next IDLE.

## Test plan
- Single read: reset, requester 0 reads 0x4000 while slave returns 0x12345678, no error -> read high in exactly one cycle, req_ready[0] two cycles after grant, req_rdata 0x12345678, req_resp 00.
- Write with strobes: requester 1 writes 0xAABBCCDD strobe 0011 to 0x0004 -> write high one cycle with address 0x4, write_data 0xAABBCCDD, byteenable 0011; req_ready[1], resp 00.
- Errors: read with address_error=1 -> read never asserted, req_rdata 0, resp 11; write with write_error=1 (0xBFF8) -> write never asserted, resp 10.
- Round-robin: REQ_COUNT=3, all three hold req_valid -> grant order 0,1,2,0,1,2; then only 0 and 2 valid after granting 2 -> next 0.
- Async reset mid-ACCESS: assert rst_n=0 while write high -> write, busy, req_ready drop without clock; after release requester 0 granted first.
- Dropped valid: requester deasserts req_valid in ACCESS -> access still completes, req_ready pulse still issued.
